// File: rtl/win_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | win_sequencer: drops, blinks and holds the win icon; drives bitmap coords.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module win_sequencer #(
  parameter int OBJECT_WIDTH_X = 32,
  parameter int OBJECT_HEIGHT_Y = 32,
  parameter int START_X = 304,
  parameter int START_Y = 0,
  parameter int TARGET_Y = 224,
  parameter int DROP_STEP = 4,
  parameter int BLINK_FRAMES = 15,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        win,
  input  logic        restart,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic        InsideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic [10:0] topLeftY,
  output logic        iconVisible,
  output logic        winDone,
  output logic [1:0]  seqState
);

  localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);
  localparam int TOG_W = $clog2(BLINK_TOGGLES + 1);
  localparam logic [10:0] START_X_C = 11'(START_X);
  localparam logic [10:0] START_Y_C = 11'(START_Y);
  localparam logic [10:0] TARGET_Y_C = 11'(TARGET_Y);
  localparam logic [11:0] TARGET_Y_W = 12'(TARGET_Y);
  localparam logic [11:0] X_END_W = 12'(START_X + OBJECT_WIDTH_X);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(BLINK_TOGGLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DROP  = 2'd1,
    ST_BLINK = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [10:0]        top_y_q, top_y_d;
  logic               vis_q, vis_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [TOG_W-1:0]   tog_cnt_q, tog_cnt_d;
  logic               win_done_q, win_done_d;
  logic               inside_q, inside_d;
  logic [10:0]        off_x_q, off_x_d;
  logic [10:0]        off_y_q, off_y_d;
  logic [11:0]        drop_sum;
  logic [11:0]        y_end;
  logic               in_x, in_y;

  always_comb begin
    state_d     = state_q;
    top_y_d     = top_y_q;
    vis_d       = vis_q;
    frame_cnt_d = frame_cnt_q;
    tog_cnt_d   = tog_cnt_q;
    win_done_d  = 1'b0;
    drop_sum    = {1'b0, top_y_q} + 12'(DROP_STEP);
    if (restart) begin
      state_d     = ST_IDLE;
      top_y_d     = START_Y_C;
      vis_d       = 1'b0;
      frame_cnt_d = '0;
      tog_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          vis_d = 1'b0;
          if (win) begin
            state_d     = ST_DROP;
            top_y_d     = START_Y_C;
            vis_d       = 1'b1;
            frame_cnt_d = '0;
            tog_cnt_d   = '0;
          end
        end
        ST_DROP: begin
          if (startOfFrame) begin
            // 12-bit sum so the clamp test cannot wrap near the top of range
            if (drop_sum >= TARGET_Y_W) begin
              top_y_d     = TARGET_Y_C;
              state_d     = ST_BLINK;
              frame_cnt_d = '0;
              tog_cnt_d   = '0;
            end else begin
              top_y_d = drop_sum[10:0];
            end
          end
        end
        ST_BLINK: begin
          if (startOfFrame) begin
            if (frame_cnt_q == FRAME_LAST) begin
              vis_d       = ~vis_q;
              frame_cnt_d = '0;
              tog_cnt_d   = tog_cnt_q + TOG_W'(1);
              if (tog_cnt_q == TOG_LAST) begin
                state_d    = ST_HOLD;
                vis_d      = 1'b1;
                win_done_d = 1'b1;
                tog_cnt_d  = '0;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
          end
        end
        ST_HOLD: begin
          vis_d   = 1'b1;
          top_y_d = TARGET_Y_C;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    y_end    = {1'b0, top_y_q} + 12'(OBJECT_HEIGHT_Y);
    in_x     = (pixelX >= START_X_C) && ({1'b0, pixelX} < X_END_W);
    in_y     = (pixelY >= top_y_q) && ({1'b0, pixelY} < y_end);
    inside_d = vis_q && in_x && in_y;
    off_x_d  = inside_d ? (pixelX - START_X_C) : 11'd0;
    off_y_d  = inside_d ? (pixelY - top_y_q) : 11'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      top_y_q     <= START_Y_C;
      vis_q       <= 1'b0;
      frame_cnt_q <= '0;
      tog_cnt_q   <= '0;
      win_done_q  <= 1'b0;
      inside_q    <= 1'b0;
      off_x_q     <= 11'd0;
      off_y_q     <= 11'd0;
    end else begin
      state_q     <= state_d;
      top_y_q     <= top_y_d;
      vis_q       <= vis_d;
      frame_cnt_q <= frame_cnt_d;
      tog_cnt_q   <= tog_cnt_d;
      win_done_q  <= win_done_d;
      inside_q    <= inside_d;
      off_x_q     <= off_x_d;
      off_y_q     <= off_y_d;
    end
  end

  assign InsideRectangle = inside_q;
  assign offsetX         = off_x_q;
  assign offsetY         = off_y_q;
  assign topLeftY        = top_y_q;
  assign iconVisible     = vis_q;
  assign winDone         = win_done_q;
  assign seqState        = state_q;

endmodule
`default_nettype wire

// File: doc/win_sequencer.md
Name: win_sequencer

Overview:
Controls the 32x32 win icon bitmap. On a win event it drops the icon from the top of the screen to a target row, blinks it a fixed number of times, then holds it on screen until restart. Every pixel clock it drives the bitmap's InsideRectangle and offsetX/offsetY inputs from the current VGA pixel coordinates. All timing is counted in VGA frames via startOfFrame.

Parameters:
OBJECT_WIDTH_X, 32, icon width in pixels
OBJECT_HEIGHT_Y, 32, icon height in pixels
START_X, 304, fixed icon left column
START_Y, 0, icon top row at drop start
TARGET_Y, 224, icon top row at end of drop
DROP_STEP, 4, pixels descended per frame
BLINK_FRAMES, 15, frames per blink half-period
BLINK_TOGGLES, 6, visibility toggles in BLINK; must be even

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
startOfFrame  in  1  one-cycle pulse per VGA frame
win  in  1  one-cycle pulse from game logic
restart  in  1  one-cycle pulse that returns the block to IDLE
pixelX  in  11  current VGA column
pixelY  in  11  current VGA row
InsideRectangle  out  1  pixel lies inside the visible icon rectangle (to bitmap)
offsetX  out  11  pixelX - topLeftX (to bitmap)
offsetY  out  11  pixelY - topLeftY (to bitmap)
topLeftY  out  11  current icon top row
iconVisible  out  1  icon currently shown
winDone  out  1  one-cycle pulse on entry to HOLD
seqState  out  2  IDLE=0, DROP=1, BLINK=2, HOLD=3 (debug)

Behaviour:
- Reset (sync, high): seqState=IDLE, topLeftY=START_Y, iconVisible=0, InsideRectangle=0, offsetX=0, offsetY=0, winDone=0, frame and toggle counters=0. Reset overrides all inputs.
- Priority each cycle: reset > restart > win > frame events.
- restart in any state: next cycle IDLE, topLeftY=START_Y, iconVisible=0, counters cleared, no winDone pulse.
- IDLE: iconVisible=0. win moves to DROP next cycle with iconVisible=1 and topLeftY=START_Y.
- win in any state other than IDLE: ignored.
- DROP: on each startOfFrame:
  - if topLeftY+DROP_STEP >= TARGET_Y, set topLeftY=TARGET_Y (clamp), go to BLINK, clear counters;
  - else topLeftY += DROP_STEP.
  - topLeftY never exceeds TARGET_Y.
- BLINK: frame counter increments on each startOfFrame.
  - When the counter equals BLINK_FRAMES-1 and startOfFrame is high: toggle iconVisible, clear the counter, increment the toggle counter.
  - When that toggle is the BLINK_TOGGLES-th: go to HOLD, force iconVisible=1, pulse winDone for exactly 1 cycle.
- HOLD: iconVisible=1, topLeftY=TARGET_Y. Only restart or reset leaves HOLD.
- Rectangle outputs are registered, 1-cycle latency from pixelX/pixelY:
  - InsideRectangle = iconVisible && pixelX in [START_X, START_X+OBJECT_WIDTH_X) && pixelY in [topLeftY, topLeftY+OBJECT_HEIGHT_Y).
  - When InsideRectangle=1: offsetX/offsetY are the 11-bit differences, always 0..31.
  - When InsideRectangle=0: offsetX/offsetY hold 0.
- topLeftY and iconVisible change only on startOfFrame cycles, or on win/restart/reset, so no mid-frame tearing from frame-driven motion.
- startOfFrame coincident with win in IDLE: entry to DROP only; no step is taken that cycle.
- Widths: all coordinate arithmetic is 11-bit unsigned. Bound comparisons use 12-bit sums so they cannot wrap.

Test Plan:
1. Reset held 3 cycles with win pulsed -> seqState=0, iconVisible=0, InsideRectangle=0, offsets 0 after release.
2. win, then 56 startOfFrame pulses -> topLeftY steps 0,4,...,224; seqState=2 after the 56th. Pixel (310,230) -> InsideRectangle=1, offsetX=6, offsetY=6 one cycle later.
3. In BLINK, 90 frames -> iconVisible toggles every 15 frames (6 toggles); winDone high exactly 1 cycle on entry to HOLD; iconVisible=1 and seqState=3.
4. Rectangle edges at topLeftY=224 -> pixel (303,224): 0; (304,224): 1 with offsets (0,0); (335,255): 1 with offsets (31,31); (336,255): 0; (304,256): 0.
5. restart during DROP at topLeftY=100, with win in the same cycle -> IDLE next cycle, topLeftY=0, iconVisible=0, no winDone; a later win restarts the drop from 0.
6. win during HOLD -> ignored, state stays 3. Sync reset mid-BLINK -> all outputs return to reset values on the next edge.
